// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose : bundles every hazard-control signal between the 5-stage datapath and the stall/flush controller.
// Latency : wires only; nothing is registered here.
// Backpressure: none; stalls are expressed through the PC_Write/IFtoID_Write/EXtoMEM_Hold enables.
// Ports   : master = controller (drives enables, PCSrc, dmem_req, status); slave = datapath side.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources from the datapath
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteReg;
    logic             MEM_Branch;
    logic             MEM_zero;
    logic             MEM_Jump;
    logic             MEM_MemRead;
    logic             MEM_MemWrite;
    logic             dmem_ready;

    // Pipeline sequencing controls
    logic             PC_Write;
    logic             IFtoID_Write;
    logic             IFtoID_Flush;
    logic             IDtoEX_Bubble;
    logic             EXtoMEM_Hold;
    logic             EXtoMEM_Bubble;
    logic             MEMtoWB_Bubble;
    logic [1:0]       PCSrc;
    logic             dmem_req;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  ID_Rs, ID_Rt, EX_MemRead, EX_WriteReg,
        input  MEM_Branch, MEM_zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, dmem_ready,
        output PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Bubble,
        output EXtoMEM_Hold, EXtoMEM_Bubble, MEMtoWB_Bubble, PCSrc,
        output dmem_req, mem_error, stall_cycles
    );

    modport slave (
        output ID_Rs, ID_Rt, EX_MemRead, EX_WriteReg,
        output MEM_Branch, MEM_zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, dmem_ready,
        input  PC_Write, IFtoID_Write, IFtoID_Flush, IDtoEX_Bubble,
        input  EXtoMEM_Hold, EXtoMEM_Bubble, MEMtoWB_Bubble, PCSrc,
        input  dmem_req, mem_error, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush controller for the 5-stage MIPS pipeline (load-use, branch/jump, multi-cycle dmem wait).
// Latency : all controls combinational from current state and inputs; FSM/counters update on posedge clk.
// Backpressure: dmem not ready freezes the whole pipe; timeout lands in a sticky ERROR freeze left only by reset.
// Ports   : clk, rst (async active-low), hz (pipeline_hazard_ctrl_if.master: hazard inputs in, enables/status out).
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_e;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_access;
    logic req;
    logic freeze;
    logic taken;
    logic redirect;
    logic load_use;

    // Hazard decode shared by next-state and output logic
    always_comb begin
        mem_access = hz.MEM_MemRead | hz.MEM_MemWrite;
        req        = mem_access & (state_q != S_ERROR);
        // ERROR behaves as a permanent freeze without a memory request
        freeze     = (req & ~hz.dmem_ready) | (state_q == S_ERROR);
        taken      = hz.MEM_Branch & hz.MEM_zero;
        redirect   = taken | hz.MEM_Jump;
        load_use   = hz.EX_MemRead & (hz.EX_WriteReg != 5'd0) &
                     ((hz.EX_WriteReg == hz.ID_Rs) | (hz.EX_WriteReg == hz.ID_Rt));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        stall_d     = stall_q;

        // Full-freeze cycles only; saturate rather than wrap
        if (freeze && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_ONE;
        end

        case (state_q)
            S_RUN: begin
                if (freeze) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            S_MEM_WAIT: begin
                if (!freeze) begin
                    // Access completed (or request withdrawn): resolve normally this cycle
                    state_d    = S_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q >= TIMEOUT) begin
                    state_d     = S_ERROR;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_ERROR: begin
                mem_error_d = 1'b1;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        hz.PC_Write       = 1'b1;
        hz.IFtoID_Write   = 1'b1;
        hz.IFtoID_Flush   = 1'b0;
        hz.IDtoEX_Bubble  = 1'b0;
        hz.EXtoMEM_Hold   = 1'b0;
        hz.EXtoMEM_Bubble = 1'b0;
        hz.MEMtoWB_Bubble = 1'b0;
        hz.PCSrc          = 2'b00;
        hz.dmem_req       = req;

        if (!rst) begin
            // Asynchronous override: pipe disabled and drained while reset is held
            hz.PC_Write       = 1'b0;
            hz.IFtoID_Write   = 1'b0;
            hz.IFtoID_Flush   = 1'b1;
            hz.IDtoEX_Bubble  = 1'b1;
            hz.EXtoMEM_Bubble = 1'b1;
            hz.MEMtoWB_Bubble = 1'b1;
            hz.dmem_req       = 1'b0;
        end else if (freeze) begin
            // Branch/jump in MEM is deliberately left unresolved until the access completes
            hz.PC_Write       = 1'b0;
            hz.IFtoID_Write   = 1'b0;
            hz.EXtoMEM_Hold   = 1'b1;
            hz.MEMtoWB_Bubble = 1'b1;
        end else if (redirect) begin
            hz.PCSrc          = hz.MEM_Jump ? 2'b10 : 2'b01;
            hz.IFtoID_Flush   = 1'b1;
            hz.IDtoEX_Bubble  = 1'b1;
            hz.EXtoMEM_Bubble = 1'b1;
        end else if (load_use) begin
            hz.PC_Write       = 1'b0;
            hz.IFtoID_Write   = 1'b0;
            hz.IDtoEX_Bubble  = 1'b1;
        end
    end

    assign hz.mem_error    = mem_error_q;
    assign hz.stall_cycles = stall_q;

endmodule
